// File: rtl/ifetch_prefetch.sv
// Instruction prefetch queue: fetches sequential words from a handshaked instruction
// memory into a DEPTH-entry FIFO and flushes/restarts on redirect.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     issue_addr_q, issue_addr_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];

  logic            has_room;
  logic            req_raw;
  logic            complete;
  logic            push;
  logic            pop;

  assign has_room = (count_q < CW'(DEPTH));

  // Request FSM: at most one read outstanding; WAIT holds the latched issue address.
  always_comb begin
    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    req_raw      = 1'b0;
    mem_addr_o   = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        req_raw    = has_room & ~redirect_i;
        mem_addr_o = fetch_pc_q;
        if (req_raw & ~mem_ack_i) begin
          state_d      = S_WAIT;
          issue_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        req_raw    = 1'b1;
        mem_addr_o = issue_addr_q;
        if (mem_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset abandons an in-flight request immediately, not at the next edge.
  assign mem_req_o = req_raw & ~reset;

  assign complete = mem_req_o & mem_ack_i;
  assign push     = complete & ~drop_q & ~redirect_i;
  assign pop      = instr_valid_o & instr_ready_i & ~redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h0000_0003;
    end else if (complete & ~drop_q) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // A redirect that lands while a read is still pending poisons that read's data.
    if (complete) begin
      drop_d = 1'b0;
    end else if ((state_q == S_WAIT) & redirect_i) begin
      drop_d = 1'b1;
    end

    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      issue_addr_q <= RESET_PC;
      drop_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      issue_addr_q <= issue_addr_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= mem_rdata_i;
      pc_q[wr_ptr_q]   <= mem_addr_o;
    end
  end

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_q[rd_ptr_q];
  assign instr_pc_o    = pc_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: vector table, directed corner cases and
// randomized traffic against a queue-level reference model.
module tb_ifetch_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DMASK = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_ready_i (instr_ready),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata)
  );

  // Reference model: queue of delivered words plus the state of the single outstanding read.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_out_addr;
  bit          m_busy;
  bit          m_drop;
  bit          p_req;
  bit          p_valid;
  logic [31:0] p_addr;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch    = RESET_PC;
    m_out_addr = RESET_PC;
    m_busy     = 0;
    m_drop     = 0;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drive one cycle's inputs, predict outputs and compare at the falling edge.
  task automatic drive(input logic rd, input logic [31:0] rpc, input logic rdy, input logic ack);
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_ack     = ack;
    p_valid     = (mq.size() != 0);
    p_req       = m_busy || ((mq.size() < DEPTH) && !rd);
    p_addr      = m_busy ? m_out_addr : m_fetch;
    mem_rdata   = p_addr ^ DMASK;
    @(negedge clk);
    chk("m_valid", 32'(instr_valid), 32'(p_valid));
    chk("m_mem_req", 32'(mem_req), 32'(p_req));
    chk("m_mem_addr", mem_addr, p_addr);
    if (p_valid) begin
      chk("m_instr_pc", instr_pc, mq[0].pc);
      chk("m_instr", instr, mq[0].instr);
    end
  endtask

  task automatic advance();
    bit   done;
    bit   popped;
    ent_t e;
    done   = p_req && mem_ack;
    popped = p_valid && instr_ready && !redirect;
    if (popped) void'(mq.pop_front());
    if (done && !m_drop && !redirect) begin
      e.instr = mem_rdata;
      e.pc    = p_addr;
      mq.push_back(e);
    end
    if (redirect) mq.delete();
    if (redirect) m_fetch = {redirect_pc[31:2], 2'b00};
    else if (done && !m_drop) m_fetch = m_fetch + 32'd4;
    if (done) begin
      m_busy = 0;
      m_drop = 0;
    end else begin
      if (redirect && m_busy) m_drop = 1;
      if (p_req && !m_busy) begin
        m_busy     = 1;
        m_out_addr = p_addr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy, input logic ack);
    drive(rd, rpc, rdy, ack);
    advance();
  endtask

  initial begin
    // Streaming with ack every cycle, then a back-pressured queue filling and draining.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h08};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h10};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h10};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h10};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h14};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h14};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h18};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1C};

    model_reset();
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) apply_reset();
      drive(1'b0, 32'h0, tbl[i].rdy, 1'b1);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_pc ^ DMASK);
      end
      advance();
    end

    // Redirect while a read is pending: the read completes, its data is dropped.
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    chk("t3_hold_req", 32'(mem_req), 32'd1);
    chk("t3_hold_addr", mem_addr, 32'h08);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    chk("t3_addr_stable", mem_addr, 32'h08);
    advance();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_new_addr", mem_addr, 32'h40);
    chk("t3_empty_after_drop", 32'(instr_valid), 32'd0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t3_first_pc", instr_pc, 32'h40);
    advance();

    // Redirect coincident with ack and ready: nothing queued, target aligned.
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h83, 1'b1, 1'b1);
    chk("t4_req", 32'(mem_req), 32'd1);
    chk("t4_addr", mem_addr, 32'h04);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_empty", 32'(instr_valid), 32'd0);
    chk("t4_next_addr", mem_addr, 32'h80);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_first_pc", instr_pc, 32'h80);
    advance();

    // Reset asserted mid-WAIT with three entries queued.
    apply_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_pending_req", 32'(mem_req), 32'd1);
    apply_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_restart_addr", mem_addr, RESET_PC);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_restart_pc", instr_pc, RESET_PC);
    advance();

    // Address wrap at the top of the 32-bit space.
    apply_reset();
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("t6_instr_top", instr, 32'hFFFF_FFFC ^ DMASK);
    chk("t6_addr_wrap", mem_addr, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_pc_wrap", instr_pc, 32'h0);
    advance();

    // Random traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step(rd, rpc, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
